imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 143 ++++++++++++++
 tb/tb_imem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction/data memory responder with a fixed access
// latency and a one-entry read hit buffer.
//
// A request that is not a hit on the buffered read address is latched and
// serviced after LATENCY wait cycles; the requester is held off with
// mem_stall meanwhile. Misaligned or out-of-range requests complete without
// touching memory and raise a one-cycle mem_err pulse.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst_n       in   asynchronous active-low reset
//   iddr_addr   in   32-bit byte address of the request
//   iddr_read   in   read request, held until served
//   iddr_write  in   write request, held until served (wins over read)
//   iddr_wdata  in   32-bit write data
//   iddr_rdata  out  registered read data for last_addr
//   mem_stall   out  combinational hold-off to the requester
//   mem_err     out  registered one-cycle pulse after a bad request completes
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | accepting requests; hits are answered with no stall
// WAIT    | latched miss in flight, cnt counts down to completion at 1

module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iddr_addr,
  input  logic        iddr_read,
  input  logic        iddr_write,
  input  logic [31:0] iddr_wdata,
  output logic [31:0] iddr_rdata,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] last_addr;
  logic        valid;

  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req_any;
  logic          hit;
  logic          miss;
  logic          done;
  logic          req_bad;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] last_idx;

  assign req_any  = iddr_read | iddr_write;
  assign hit      = iddr_read & ~iddr_write & valid & (iddr_addr == last_addr);
  assign miss     = (state == ST_IDLE) & req_any & ~hit;
  assign done     = (state == ST_WAIT) & (cnt == 4'd1);
  assign req_idx  = req_addr[AW+1:2];
  assign last_idx = last_addr[AW+1:2];
  assign req_bad  = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);

  // A completing write releases the requester one cycle early: the write
  // lands at the edge, so nothing downstream needs to wait for it.
  always_comb begin
    mem_stall = 1'b0;
    if (rst_n) begin
      if (state == ST_IDLE) begin
        mem_stall = req_any & ~hit;
      end else begin
        mem_stall = ~(done & req_write);
      end
    end
  end

  // Request capture; pure data, no reset needed. Inputs are ignored in WAIT.
  always_ff @(posedge clk) begin
    if (miss) begin
      req_addr  <= iddr_addr;
      req_wdata <= iddr_wdata;
      req_write <= iddr_write;
    end
  end

  // Storage is never reset. Reset forces IDLE asynchronously, so an access
  // aborted by reset can never reach the write below.
  always_ff @(posedge clk) begin
    if (done && req_write && !req_bad) begin
      mem[req_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      valid      <= 1'b0;
      last_addr  <= 32'd0;
      iddr_rdata <= 32'd0;
      mem_err    <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (miss) begin
            cnt   <= LAT;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= ST_IDLE;
            mem_err <= req_bad;
            if (req_write) begin
              // The buffered word may be stale now; force the next read to refetch.
              if (req_idx == last_idx) begin
                valid <= 1'b0;
              end
            end else begin
              iddr_rdata <= req_bad ? 32'd0 : mem[req_idx];
              last_addr  <= req_addr;
              valid      <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iddr_addr;
  logic        iddr_read;
  logic        iddr_write;
  logic [31:0] iddr_wdata;
  logic [31:0] iddr_rdata;
  logic        mem_stall;
  logic        mem_err;

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iddr_addr  (iddr_addr),
    .iddr_read  (iddr_read),
    .iddr_write (iddr_write),
    .iddr_wdata (iddr_wdata),
    .iddr_rdata (iddr_rdata),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: word store, one cached read address, and the data the
  // responder is expected to be presenting.
  logic [31:0] ref_mem [int];
  logic [31:0] ref_last  = 32'd0;
  logic        ref_valid = 1'b0;
  logic [31:0] ref_rdata = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a % (DEPTH * 4)) / 4);
  endfunction

  task automatic drive_idle();
    iddr_read  = 1'b0;
    iddr_write = 1'b0;
    iddr_addr  = $urandom;
    iddr_wdata = $urandom;
  endtask

  // One requester transaction: hold the request until mem_stall drops, then
  // one idle cycle to catch a late mem_err. With jitter, inputs are scrambled
  // during cycles the responder should be ignoring them.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit jitter);
    logic        hit;
    logic        bad;
    int          exp_stall;
    int          exp_errs;
    logic [31:0] exp_rdata;
    int          c;
    int          stalls;
    int          errs;
    hit       = rd && !wr && ref_valid && (addr == ref_last);
    bad       = bad_addr(addr);
    exp_stall = hit ? 0 : (wr ? LAT : LAT + 1);
    exp_errs  = (!hit && bad) ? 1 : 0;
    if (hit)      exp_rdata = ref_rdata;
    else if (bad) exp_rdata = 32'd0;
    else          exp_rdata = ref_mem.exists(widx(addr)) ? ref_mem[widx(addr)] : 32'hx;
    stalls = 0;
    errs   = 0;
    for (c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (jitter && c > 0 && c < exp_stall) begin
        iddr_read  = 1'($urandom);
        iddr_write = 1'($urandom);
        iddr_addr  = $urandom;
        iddr_wdata = $urandom;
      end else begin
        iddr_read  = rd;
        iddr_write = wr;
        iddr_addr  = addr;
        iddr_wdata = wdata;
      end
      @(negedge clk);
      errs += int'(mem_err);
      if (!mem_stall) break;
      stalls++;
    end
    check_val({tag, "_served"}, 32'(c < 40), 32'd1);
    check_val({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
    if (rd && !wr) check_val({tag, "_rdata"}, iddr_rdata, exp_rdata);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    errs += int'(mem_err);
    check_val({tag, "_idle_stall"}, 32'(mem_stall), 32'd0);
    check_val({tag, "_err"}, 32'(errs), 32'(exp_errs));
    if (!hit) begin
      if (wr) begin
        if (!bad) ref_mem[widx(addr)] = wdata;
        if (widx(addr) == widx(ref_last)) ref_valid = 1'b0;
      end else begin
        ref_rdata = exp_rdata;
        ref_last  = addr;
        ref_valid = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic        rd;
    logic        wr;
    int          r;

    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_rdata", iddr_rdata, 32'd0);
    check_val("rst_stall", 32'(mem_stall), 32'd0);
    check_val("rst_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) do_req("preload", 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    do_req("wr0_13",     1'b0, 1'b1, 32'h0,   32'h00000013, 1'b0);
    do_req("rd0_miss",   1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
    do_req("rd0_hit",    1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
    do_req("wr10",       1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0);
    do_req("rd10",       1'b1, 1'b0, 32'h10,  32'h0,        1'b0);
    do_req("rd0_again",  1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
    do_req("rd0_hit2",   1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
    do_req("wr0_inval",  1'b0, 1'b1, 32'h0,   32'h12345678, 1'b0);
    do_req("rd0_refill", 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
    do_req("rd6_bad",    1'b1, 1'b0, 32'h6,   32'h0,        1'b0);
    do_req("rd6_badhit", 1'b1, 1'b0, 32'h6,   32'h0,        1'b0);
    do_req("wr400_bad",  1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0);
    do_req("rd0_intact", 1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
    do_req("rdwr8",      1'b1, 1'b1, 32'h8,   32'hA5A5A5A5, 1'b0);
    do_req("rd8",        1'b1, 1'b0, 32'h8,   32'h0,        1'b0);

    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      a = 32'($urandom_range(0, 15) * 4);
      else if (r == 6) a = ref_last;
      else if (r == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'(DEPTH * 4 + $urandom_range(0, 63) * 4);
      else             a = $urandom | 32'h8000_0000;
      r = int'($urandom_range(0, 9));
      rd = (r <= 5) || (r == 9);
      wr = (r >= 6);
      do_req("rand", rd, wr, a, $urandom, 1'b1);
    end

    // Reset while a write to 0x20 is waiting.
    do_req("rst_pre_rd0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    iddr_read  = 1'b0;
    iddr_write = 1'b1;
    iddr_addr  = 32'h20;
    iddr_wdata = 32'h0BADF00D;
    @(negedge clk);
    check_val("rstw_c0_stall", 32'(mem_stall), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rstw_stall", 32'(mem_stall), 32'd0);
    check_val("rstw_rdata", iddr_rdata, 32'd0);
    check_val("rstw_err", 32'(mem_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check_val("rstw_hold_stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;
    ref_valid = 1'b0;
    ref_rdata = 32'd0;
    do_req("rst_rd0_miss", 1'b1, 1'b0, 32'h0,  32'h0, 1'b0);
    do_req("rst_rd20",     1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
